audio_equalizer: RTL and testbench
==================================

AUDIO_EQUALIZER -- requirements
Module: audio_equalizer

Interface
REQ-001 Parameter WD_IN, default 24: input sample width, signed two's complement.
REQ-002 Parameter WD_OUT, default 24: single-band output width.
REQ-003 Parameter WD_GAIN, default 4: band gain width, unsigned, range 0..15.
REQ-004 Parameters G_LOW, G_MID, G_HIGH, default 1 each: per-band gains, WD_GAIN bits.
REQ-005 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port i_reset, input, 1: reset, asynchronous, active-high.
REQ-007 Port i_data_audio, input, WD_IN: one new signed audio sample every clock.
REQ-008 Port o_data_audio, output, WD_OUT+4 (28): signed equalized sum of three bands.
REQ-009 Port o_data_single_band, output, WD_OUT (24): signed low-band (lowpass FIR) output.

Function
REQ-010 An 8-entry signed delay line d0..d7 SHALL shift every clock; d0 <= i_data_audio, dk <= d(k-1).
REQ-011 Low band SHALL be L = (d0+...+d7) >>> 3, using full-precision sum, arithmetic shift (floor).
REQ-012 Two-tap band SHALL be L2 = (d0+d1) >>> 1, arithmetic shift (floor).
REQ-013 Mid band SHALL be M = L2 - L; high band H = d0 - L2; both held at 25 bits signed.
REQ-014 With unit gains, L+M+H SHALL equal d0 exactly.
REQ-015 Equalized sum S = G_LOW*L + G_MID*M + G_HIGH*H SHALL be computed at 31 bits signed with gains zero-extended.
REQ-016 S SHALL be reduced to 28 bits per REQ-023/REQ-024 and registered into o_data_audio.
REQ-017 L SHALL be registered into o_data_single_band; L always fits 24 bits, no clipping.
REQ-018 Latency SHALL be 2 edges: a sample applied before edge k is captured at edge k and is reflected in both outputs after edge k+1.
REQ-019 No handshake or valid signal; throughput SHALL be one sample per clock, continuous.

Reset
REQ-020 While i_reset=1, d0..d7, o_data_audio and o_data_single_band SHALL be 0, immediately and without waiting for a clock edge.
REQ-021 After release, the delay line SHALL refill from zeros; the first edge after release captures a sample.
REQ-022 Reset asserted mid-stream SHALL discard all history; there is no partial-state retention.

Configuration
REQ-023 With macro AUDIO_EQ_SATURATE_EN defined, S SHALL saturate: S > 2^27-1 gives 0x7FFFFFF, S < -2^27 gives 0x8000000.
REQ-024 Without AUDIO_EQ_SATURATE_EN, o_data_audio SHALL be S[27:0] (two's-complement wrap).

Verification
REQ-025 Assert i_reset during streaming of nonzero data -> both outputs read 0 at once; after release, first nonzero output appears 2 edges after first sample.
REQ-026 Unity gains, constant input 0x000100 -> o_data_audio = 0x0000100 from the first output; o_data_single_band = 0x20, 0x40, ..., 0x100, then holds 0x100.
REQ-027 G_LOW=2, G_MID=0, G_HIGH=0, impulse 0x000800 followed by zeros -> o_data_audio = 0x0000200 for 8 consecutive cycles, then 0.
REQ-028 Unity gains, random 24-bit stream -> o_data_audio equals sign-extended input delayed 2 edges, every cycle.
REQ-029 G_LOW=0, G_MID=15, G_HIGH=15; input 0x7FFFFF held 8+ cycles, then one 0x800000 -> on the step output: 0x8000000 with AUDIO_EQ_SATURATE_EN defined, 0x2E0000F without it.
REQ-030 Unity gains, alternating 0x7FFFFF / 0x800000 -> o_data_audio tracks the input exactly; no saturation and no wrap occur.

Source files
------------

// File: rtl/audio_equalizer.sv
// Three-band audio equalizer: 8-tap moving-average low band, two-tap split into mid/high, gain-weighted sum.
// Build option AUDIO_EQ_SATURATE_EN clamps the 28-bit equalized output instead of wrapping it.
module audio_equalizer #(
    parameter int                 WD_IN   = 24,
    parameter int                 WD_OUT  = 24,
    parameter int                 WD_GAIN = 4,
    parameter logic [WD_GAIN-1:0] G_LOW   = WD_GAIN'(1'b1),
    parameter logic [WD_GAIN-1:0] G_MID   = WD_GAIN'(1'b1),
    parameter logic [WD_GAIN-1:0] G_HIGH  = WD_GAIN'(1'b1)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic signed [WD_IN-1:0]  i_data_audio,
    output logic signed [WD_OUT+3:0] o_data_audio,
    output logic signed [WD_OUT-1:0] o_data_single_band
);

    localparam int WD_SUM  = WD_IN + 3;
    localparam int WD_BAND = WD_IN + 1;
    localparam int WD_ACC  = WD_BAND + WD_GAIN + 2;
    localparam int WD_Y    = WD_OUT + 4;

    logic signed [WD_IN-1:0]   dly_r [8];
    logic signed [WD_SUM-1:0]  sum8_s;
    logic signed [WD_BAND-1:0] sum2_s;
    logic signed [WD_BAND-1:0] low_s;
    logic signed [WD_BAND-1:0] two_s;
    logic signed [WD_BAND-1:0] mid_s;
    logic signed [WD_BAND-1:0] high_s;
    logic signed [WD_ACC-1:0]  acc_s;
    logic signed [WD_Y-1:0]    y_s;

    // Gains are unsigned, so they enter the product with a zero sign bit.
    function automatic logic signed [WD_ACC-1:0] mul_gain(
        input logic signed [WD_BAND-1:0] band,
        input logic        [WD_GAIN-1:0] gain
    );
        logic signed [WD_GAIN:0] gain_s;
        gain_s = {1'b0, gain};
        return WD_ACC'(band) * WD_ACC'(gain_s);
    endfunction

    // Sample delay line, cleared immediately by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 8; i++) begin
                dly_r[i] <= '0;
            end
        end else begin
            dly_r[0] <= i_data_audio;
            for (int i = 1; i < 8; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Band split and weighted sum; mid and high are complements so unit gains reproduce d0.
    always_comb begin
        sum8_s = '0;
        for (int k = 0; k < 8; k++) begin
            sum8_s = sum8_s + WD_SUM'(dly_r[k]);
        end
        low_s  = WD_BAND'(sum8_s >>> 2'd3);
        sum2_s = WD_BAND'(dly_r[0]) + WD_BAND'(dly_r[1]);
        two_s  = sum2_s >>> 1'd1;
        mid_s  = two_s - low_s;
        high_s = WD_BAND'(dly_r[0]) - two_s;
        acc_s  = mul_gain(low_s, G_LOW) + mul_gain(mid_s, G_MID) + mul_gain(high_s, G_HIGH);
    end

`ifdef AUDIO_EQ_SATURATE_EN
    // Clamp when the bits above the output sign bit disagree with it.
    always_comb begin
        y_s = acc_s[WD_Y-1:0];
        if ((~|acc_s[WD_ACC-1:WD_Y-1]) || (&acc_s[WD_ACC-1:WD_Y-1])) begin
            y_s = acc_s[WD_Y-1:0];
        end else if (acc_s[WD_ACC-1]) begin
            y_s = {1'b1, {(WD_Y-1){1'b0}}};
        end else begin
            y_s = {1'b0, {(WD_Y-1){1'b1}}};
        end
    end
`else
    logic unused_acc_s;
    assign unused_acc_s = ^acc_s[WD_ACC-1:WD_Y];

    // Two's-complement wrap to the output width.
    always_comb begin
        y_s = acc_s[WD_Y-1:0];
    end
`endif

    // Output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data_audio       <= '0;
            o_data_single_band <= '0;
        end else begin
            o_data_audio       <= y_s;
            o_data_single_band <= low_s[WD_OUT-1:0];
        end
    end

endmodule

// File: tb/tb_audio_equalizer.sv
// Scoreboard bench for audio_equalizer: three gain configurations share one input stream.
module tb_audio_equalizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [23:0] data_in;
    logic [27:0] aud_u, aud_l, aud_h;
    logic [23:0] sb_u, sb_l, sb_h;
    logic [23:0] prev_x;

    int n_checks = 0;
    int n_fail   = 0;

    longint hist [8];

    typedef struct {
        logic [27:0] a_u;
        logic [27:0] a_l;
        logic [27:0] a_h;
        logic [23:0] sb;
    } exp_t;
    exp_t sb_q [$];

    audio_equalizer #(.G_LOW(4'd1), .G_MID(4'd1), .G_HIGH(4'd1)) u_unity (
        .i_clk(clk), .i_reset(rst), .i_data_audio(data_in),
        .o_data_audio(aud_u), .o_data_single_band(sb_u));

    audio_equalizer #(.G_LOW(4'd2), .G_MID(4'd0), .G_HIGH(4'd0)) u_low (
        .i_clk(clk), .i_reset(rst), .i_data_audio(data_in),
        .o_data_audio(aud_l), .o_data_single_band(sb_l));

    audio_equalizer #(.G_LOW(4'd0), .G_MID(4'd15), .G_HIGH(4'd15)) u_hp (
        .i_clk(clk), .i_reset(rst), .i_data_audio(data_in),
        .o_data_audio(aud_h), .o_data_single_band(sb_h));

    function automatic logic [27:0] model_eq(input longint gl, input longint gm, input longint gh);
        longint sum, l, l2, s;
        sum = 0;
        for (int k = 0; k < 8; k++) sum += hist[k];
        l  = sum >>> 3;
        l2 = (hist[0] + hist[1]) >>> 1;
        s  = gl * l + gm * (l2 - l) + gh * (hist[0] - l2);
`ifdef AUDIO_EQ_SATURATE_EN
        if (s > 64'sd134217727) return 28'h7FFFFFF;
        if (s < -64'sd134217728) return 28'h8000000;
`endif
        return s[27:0];
    endfunction

    function automatic logic [23:0] model_low();
        longint sum, l;
        sum = 0;
        for (int k = 0; k < 8; k++) sum += hist[k];
        l = sum >>> 3;
        return l[23:0];
    endfunction

    function automatic logic [27:0] sext(input logic [23:0] x);
        return {{4{x[23]}}, x};
    endfunction

    task automatic model_reset();
        exp_t z;
        for (int k = 0; k < 8; k++) hist[k] = 0;
        sb_q.delete();
        z.a_u = 28'h0; z.a_l = 28'h0; z.a_h = 28'h0; z.sb = 24'h0;
        sb_q.push_back(z);
        prev_x = 24'h0;
    endtask

    task automatic restart();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_sample(input logic [23:0] x);
        exp_t e;
        data_in = x;
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(x));
        e.a_u = model_eq(1, 1, 1);
        e.a_l = model_eq(2, 0, 0);
        e.a_h = model_eq(0, 15, 15);
        e.sb  = model_low();
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_in = 24'h123456;
        #2;
        n_checks++;
        if ({aud_u, aud_l, aud_h, sb_u, sb_l, sb_h} !== 132'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h %h %h %h required all 0", aud_u, aud_l, aud_h, sb_u);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({aud_u, aud_l, aud_h, sb_u, sb_l, sb_h} !== 132'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h %h %h %h required all 0", aud_u, aud_l, aud_h, sb_u);
        end
    endtask

    task automatic test_dc();
        exp_t e;
        logic [23:0] want_sb;
        restart();
        for (int n = 1; n <= 11; n++) begin
            drive_sample(24'h000100);
            e = sb_q.pop_front();
            n_checks++;
            if ({aud_u, aud_l, aud_h, sb_u, sb_l, sb_h} !== {e.a_u, e.a_l, e.a_h, e.sb, e.sb, e.sb}) begin
                n_fail++;
                $display("FAIL dc_model step %0d: got %h %h %h %h required %h %h %h %h",
                         n, aud_u, aud_l, aud_h, sb_u, e.a_u, e.a_l, e.a_h, e.sb);
            end
            if (n >= 2) begin
                want_sb = (n - 1 >= 8) ? 24'h000100 : 24'(32 * (n - 1));
                n_checks++;
                if (aud_u !== 28'h0000100 || sb_u !== want_sb) begin
                    n_fail++;
                    $display("FAIL dc_const step %0d: got audio %h band %h required %h %h",
                             n, aud_u, sb_u, 28'h0000100, want_sb);
                end
            end
        end
    endtask

    task automatic test_impulse();
        exp_t e;
        logic [27:0] want;
        restart();
        for (int n = 1; n <= 12; n++) begin
            drive_sample((n == 1) ? 24'h000800 : 24'h000000);
            e = sb_q.pop_front();
            want = (n >= 2 && n <= 9) ? 28'h0000200 : 28'h0000000;
            n_checks++;
            if (aud_l !== want || aud_l !== e.a_l) begin
                n_fail++;
                $display("FAIL impulse_low step %0d: got %h required %h (model %h)", n, aud_l, want, e.a_l);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [23:0] x;
        restart();
        for (int n = 0; n < 200; n++) begin
            x = 24'($urandom);
            drive_sample(x);
            e = sb_q.pop_front();
            n_checks++;
            if ({aud_u, aud_l, aud_h, sb_u, sb_l, sb_h} !== {e.a_u, e.a_l, e.a_h, e.sb, e.sb, e.sb}) begin
                n_fail++;
                $display("FAIL random_model step %0d: got %h %h %h %h required %h %h %h %h",
                         n, aud_u, aud_l, aud_h, sb_u, e.a_u, e.a_l, e.a_h, e.sb);
            end
            n_checks++;
            if (aud_u !== sext(prev_x)) begin
                n_fail++;
                $display("FAIL random_passthru step %0d: got %h required %h", n, aud_u, sext(prev_x));
            end
            prev_x = x;
        end
    endtask

    task automatic test_step_sat();
        exp_t e;
        logic [27:0] want;
`ifdef AUDIO_EQ_SATURATE_EN
        want = 28'h8000000;
`else
        want = 28'h2E0000F;
`endif
        restart();
        for (int n = 1; n <= 11; n++) begin
            drive_sample((n <= 9) ? 24'h7FFFFF : ((n == 10) ? 24'h800000 : 24'h000000));
            e = sb_q.pop_front();
            n_checks++;
            if ({aud_u, aud_l, aud_h, sb_u, sb_l, sb_h} !== {e.a_u, e.a_l, e.a_h, e.sb, e.sb, e.sb}) begin
                n_fail++;
                $display("FAIL step_model step %0d: got %h %h %h %h required %h %h %h %h",
                         n, aud_u, aud_l, aud_h, sb_u, e.a_u, e.a_l, e.a_h, e.sb);
            end
        end
        n_checks++;
        if (aud_h !== want) begin
            n_fail++;
            $display("FAIL step_high_gain: got %h required %h", aud_h, want);
        end
    endtask

    task automatic test_alternate();
        exp_t e;
        logic [23:0] x;
        restart();
        for (int n = 0; n < 20; n++) begin
            x = n[0] ? 24'h800000 : 24'h7FFFFF;
            drive_sample(x);
            e = sb_q.pop_front();
            n_checks++;
            if (aud_u !== sext(prev_x) || aud_u !== e.a_u || aud_h !== e.a_h) begin
                n_fail++;
                $display("FAIL alternate step %0d: got %h %h required %h %h", n, aud_u, aud_h, sext(prev_x), e.a_h);
            end
            prev_x = x;
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        restart();
        for (int n = 0; n < 10; n++) begin
            drive_sample(24'($urandom) | 24'h000001);
            e = sb_q.pop_front();
            n_checks++;
            if ({aud_u, aud_l, aud_h, sb_u} !== {e.a_u, e.a_l, e.a_h, e.sb}) begin
                n_fail++;
                $display("FAIL midstream_model step %0d: got %h %h %h %h required %h %h %h %h",
                         n, aud_u, aud_l, aud_h, sb_u, e.a_u, e.a_l, e.a_h, e.sb);
            end
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({aud_u, aud_l, aud_h, sb_u, sb_l, sb_h} !== 132'h0) begin
            n_fail++;
            $display("FAIL midstream_reset_async: got %h %h %h %h required all 0", aud_u, aud_l, aud_h, sb_u);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive_sample(24'h000400);
        e = sb_q.pop_front();
        n_checks++;
        if (aud_u !== 28'h0 || sb_u !== 24'h0 || aud_u !== e.a_u) begin
            n_fail++;
            $display("FAIL midstream_first_edge: got %h %h required 0 0", aud_u, sb_u);
        end
        drive_sample(24'h000400);
        e = sb_q.pop_front();
        n_checks++;
        if (aud_u !== 28'h0000400 || sb_u !== 24'h000080 || sb_u !== e.sb) begin
            n_fail++;
            $display("FAIL midstream_second_edge: got %h %h required %h %h", aud_u, sb_u, 28'h0000400, 24'h000080);
        end
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1;
        data_in = 24'h0;
        prev_x = 24'h0;
        test_reset();
        test_dc();
        test_impulse();
        test_random();
        test_step_sat();
        test_alternate();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
